// File: rtl/bus_region_pkg.sv
// Shared types and helpers for the external-bus region controller.
package bus_region_pkg;

  // Width of the per-region wait-state count.
  localparam int unsigned WaitW = 4;

  // Largest supported region count.
  localparam int unsigned MaxReg = 16;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StAccess,
    StHold,
    StErr
  } state_e;

  // Wait-count vectors are widened to the maximum region count before field extraction.
  typedef logic [MaxReg*WaitW-1:0] wait_vec_t;

  // Return wait-state field i of a packed wait vector.
  function automatic logic [WaitW-1:0] wait_field(input wait_vec_t vec, input int unsigned i);
    return vec[i*WaitW +: WaitW];
  endfunction

endpackage

// File: rtl/region_match.sv
// Combinational base/mask region decoder; the lowest matching index wins.
module region_match #(
  parameter int ADDR_W = 32,
  parameter int NREG = 4,
  parameter int IDX_W = 2,
  parameter logic [NREG*ADDR_W-1:0] REG_BASE = '0,
  parameter logic [NREG*ADDR_W-1:0] REG_MASK = '0
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [IDX_W-1:0]  hit_idx
);

  // Scan upward and keep only the first match so overlapping regions resolve to the lowest index.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < NREG; i++) begin
      if (!hit && ((addr & REG_MASK[i*ADDR_W +: ADDR_W]) == REG_BASE[i*ADDR_W +: ADDR_W])) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/bus_region_ctrl.sv
// External-bus chip-select controller: decodes a request against NREG regions and sequences
// registered active-low CS/OE/WE strobes, ending each request with a one-cycle ack or err.
module bus_region_ctrl
  import bus_region_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int NREG = 4,
  parameter logic [NREG*ADDR_W-1:0] REG_BASE = '0,
  parameter logic [NREG*ADDR_W-1:0] REG_MASK = '0,
  parameter logic [NREG*4-1:0]      REG_WAIT = '0,
  parameter logic [NREG-1:0]        REG_RO   = '0,
  localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  output logic              busy,
  output logic              ack,
  output logic              err,
  output logic [NREG-1:0]   cs_n,
  output logic              oe_n,
  output logic              we_n,
  output logic [IDX_W-1:0]  hit_idx
);

  localparam wait_vec_t WaitAll = wait_vec_t'(REG_WAIT);

  logic             m_hit;
  logic [IDX_W-1:0] m_idx;

  state_e           state;
  logic [WaitW-1:0] cnt;
  logic             wr;

  region_match #(
    .ADDR_W   (ADDR_W),
    .NREG     (NREG),
    .IDX_W    (IDX_W),
    .REG_BASE (REG_BASE),
    .REG_MASK (REG_MASK)
  ) u_match (
    .addr    (addr),
    .hit     (m_hit),
    .hit_idx (m_idx)
  );

  // Sequencing FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= StIdle;
      cnt     <= '0;
      wr      <= 1'b0;
      busy    <= 1'b0;
      ack     <= 1'b0;
      err     <= 1'b0;
      cs_n    <= '1;
      oe_n    <= 1'b1;
      we_n    <= 1'b1;
      hit_idx <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          ack <= 1'b0;
          err <= 1'b0;
          if (req) begin
            busy <= 1'b1;
            if (!m_hit || (REG_RO[m_idx] && we)) begin
              state <= StErr;
              err   <= 1'b1;
            end else begin
              state   <= StSetup;
              hit_idx <= m_idx;
              wr      <= we;
              cnt     <= wait_field(WaitAll, int'(m_idx));
              cs_n    <= ~(NREG'(1) << m_idx);
            end
          end
        end
        StSetup: begin
          state <= StAccess;
          oe_n  <= wr;
          we_n  <= ~wr;
        end
        StAccess: begin
          // Counter was loaded with W, so ACCESS spans W+1 cycles and never wraps.
          if (cnt == '0) begin
            state <= StHold;
            oe_n  <= 1'b1;
            we_n  <= 1'b1;
            ack   <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        StHold: begin
          state <= StIdle;
          ack   <= 1'b0;
          busy  <= 1'b0;
          cs_n  <= '1;
        end
        StErr: begin
          state <= StIdle;
          err   <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_region_ctrl.sv
// Bench for bus_region_ctrl: directed scenarios plus random traffic against a cycle-count model.
module tb_bus_region_ctrl;

  localparam int ADDR_W = 32;
  localparam int NREG = 4;

  localparam logic [NREG*ADDR_W-1:0] BASE = {32'h4000_0000, 32'h0002_0000, 32'h0001_0000,
                                             32'h0000_0000};
  localparam logic [NREG*ADDR_W-1:0] MASK = {32'hFFFF_F000, 32'hFFFF_0000, 32'hFFFF_0000,
                                             32'hFFFF_0000};
  localparam logic [NREG*4-1:0] WAITS = {4'd1, 4'd0, 4'd2, 4'd3};
  localparam logic [NREG-1:0]   RO    = 4'b0001;

  logic              clk = 1'b0;
  logic              reset;
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic              busy;
  logic              ack;
  logic              err;
  logic [NREG-1:0]   cs_n;
  logic              oe_n;
  logic              we_n;
  logic [1:0]        hit_idx;

  always #5 clk = ~clk;

  bus_region_ctrl #(
    .ADDR_W   (ADDR_W),
    .NREG     (NREG),
    .REG_BASE (BASE),
    .REG_MASK (MASK),
    .REG_WAIT (WAITS),
    .REG_RO   (RO)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .addr    (addr),
    .we      (we),
    .busy    (busy),
    .ack     (ack),
    .err     (err),
    .cs_n    (cs_n),
    .oe_n    (oe_n),
    .we_n    (we_n),
    .hit_idx (hit_idx)
  );

  // Region table as plain data.
  logic [31:0] r_base [4] = '{32'h0000_0000, 32'h0001_0000, 32'h0002_0000, 32'h4000_0000};
  logic [31:0] r_mask [4] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_F000};
  int          r_wait [4] = '{3, 2, 0, 1};
  bit          r_ro   [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

  int n_total = 0;
  int n_bad = 0;
  int ack_cnt = 0;

  // Model: k counts cycles since the acceptance edge of the request in flight.
  bit act = 1'b0;
  bit is_err = 1'b0;
  bit m_wr = 1'b0;
  int k = 0;
  int m_w = 0;
  int m_idx = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int h;
    if (reset) begin
      act = 1'b0;
    end else if (act) begin
      k++;
      if (is_err ? (k > 1) : (k > m_w + 3)) act = 1'b0;
    end else if (req) begin
      h = -1;
      for (int i = 0; i < 4; i++) begin
        if (h < 0 && ((addr & r_mask[i]) == r_base[i])) h = i;
      end
      act = 1'b1;
      k = 1;
      if (h < 0 || (r_ro[h] && we)) begin
        is_err = 1'b1;
      end else begin
        is_err = 1'b0;
        m_idx = h;
        m_w = r_wait[h];
        m_wr = we;
      end
    end
  endtask

  task automatic check_outputs();
    logic [3:0] e_cs;
    bit acc;
    bit good;
    good = act && !is_err;
    acc = good && k >= 2 && k <= m_w + 2;
    e_cs = good ? ~(4'b0001 << m_idx) : 4'hF;
    check_eq("busy", busy, act);
    check_eq("ack", ack, good && k == m_w + 3);
    check_eq("err", err, act && is_err);
    check_eq("cs_n", cs_n, e_cs);
    check_eq("oe_n", oe_n, !(acc && !m_wr));
    check_eq("we_n", we_n, !(acc && m_wr));
    if (good) check_eq("hit_idx", hit_idx, m_idx);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (ack) ack_cnt++;
    check_outputs();
  endtask

  task automatic do_req(input logic [31:0] a, input logic w);
    req = 1'b1;
    addr = a;
    we = w;
    tick();
    req = 1'b0;
    for (int i = 0; i < 40 && act; i++) begin
      addr = $urandom;
      we = 1'($urandom_range(0, 1));
      tick();
    end
    tick();
  endtask

  initial begin
    int sel;
    reset = 1'b1;
    req = 1'b0;
    addr = '0;
    we = 1'b0;
    tick();
    tick();
    check_eq("rst_hit_idx", hit_idx, 0);
    check_eq("rst_cs_n", cs_n, 4'hF);
    reset = 1'b0;
    tick();

    do_req(32'h0000_1234, 1'b0);
    do_req(32'h0002_0010, 1'b1);
    do_req(32'h0000_0004, 1'b1);
    do_req(32'h8000_0000, 1'b0);

    // req held high: one ack per 6 cycles.
    ack_cnt = 0;
    req = 1'b1;
    addr = 32'h0001_0040;
    we = 1'b0;
    for (int i = 0; i < 24; i++) tick();
    check_eq("held_acks", ack_cnt, 4);
    req = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    // Reset during ACCESS of an R1 write.
    req = 1'b1;
    addr = 32'h0001_0020;
    we = 1'b1;
    tick();
    req = 1'b0;
    tick();
    tick();
    check_eq("pre_rst_we_n", we_n, 0);
    reset = 1'b1;
    tick();
    check_eq("abort_we_n", we_n, 1);
    check_eq("abort_cs_n", cs_n, 4'hF);
    check_eq("abort_busy", busy, 0);
    reset = 1'b0;
    ack_cnt = 0;
    for (int i = 0; i < 8; i++) tick();
    check_eq("abort_no_ack", ack_cnt, 0);

    do_req(32'h4000_0FFC, 1'b0);
    do_req(32'h4000_1000, 1'b0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      req = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 4);
      if (sel < 4) addr = r_base[sel] | ($urandom & ~r_mask[sel]);
      else addr = $urandom;
      tick();
    end
    reset = 1'b0;
    req = 1'b0;
    for (int i = 0; i < 20; i++) tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
